// File: rtl/bus_pkg.sv
// Shared types and address-map constants for the CPU bus decoder.
package bus_pkg;

   // Peripheral region driven on periph_select_o; REGION_NONE marks work-RAM cycles.
   typedef enum logic [1:0] {
      REGION_NONE   = 2'd0,
      REGION_PPU    = 2'd1,
      REGION_APU_IO = 2'd2,
      REGION_CART   = 2'd3
   } region_t;

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      RAM_ACCESS  = 2'd1,
      PERIPH_WAIT = 2'd2,
      RESPOND     = 2'd3
   } state_t;

   localparam logic [15:0] WRAM_END = 16'h1FFF;
   localparam logic [15:0] PPU_END  = 16'h3FFF;
   localparam logic [15:0] IO_END   = 16'h401F;
   localparam logic [15:0] PPU_BASE = 16'h2000;

   // Map a CPU address onto its region of the NES memory map.
   function automatic region_t decode_region(input logic [15:0] addr);
      if (addr <= WRAM_END)    return REGION_NONE;
      else if (addr <= PPU_END) return REGION_PPU;
      else if (addr <= IO_END)  return REGION_APU_IO;
      else                      return REGION_CART;
   endfunction

   // Address presented to the peripheral; the eight PPU registers repeat every 8 bytes.
   function automatic logic [15:0] periph_address(input logic [15:0] addr);
      if (decode_region(addr) == REGION_PPU) return PPU_BASE | {13'd0, addr[2:0]};
      return addr;
   endfunction

endpackage

// File: rtl/work_ram.sv
// Single-port 2^ADDR_BITS x 8 work RAM, one-cycle registered read, suited to ECP5 block RAM.
module work_ram #(
   parameter int ADDR_BITS = 11
) (
   input  logic                 clock_i,
   input  logic [ADDR_BITS-1:0] addr_i,
   input  logic                 we_i,
   input  logic [7:0]           wdata_i,
   output logic [7:0]           rdata_o
);

   // NOTE: the array and its read register have no reset; resetting them prevents block-RAM inference.
   logic [7:0] mem_q [2**ADDR_BITS];
   logic [7:0] rdata_q;

   // Synchronous write and registered read (read returns the old contents on a same-address write).
   always_ff @(posedge clock_i) begin
      if (we_i) mem_q[addr_i] <= wdata_i;
      rdata_q <= mem_q[addr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/cpu_bus_decoder.sv
// Accepts CPU bus cycles, serves $0000-$1FFF from mirrored work RAM and forwards
// everything else to a req/ack peripheral port with timeout and open-bus reads.
// TIMEOUT_CYCLES + 3 must stay below the CPU clock divider (12) so the next strobe finds IDLE.
module cpu_bus_decoder
   import bus_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 8,
   parameter int RAM_ADDR_BITS  = 11
) (
   input  logic        clock_i,
   input  logic        reset_i,
   input  logic [15:0] cpu_address_i,
   input  logic        cpu_address_valid_i,
   input  logic [7:0]  cpu_data_i,
   input  logic        cpu_data_valid_i,
   output logic [7:0]  cpu_data_o,
   output logic        cpu_data_valid_o,
   output logic [1:0]  periph_select_o,
   output logic [15:0] periph_address_o,
   output logic        periph_write_o,
   output logic [7:0]  periph_wdata_o,
   output logic        periph_req_o,
   input  logic        periph_ack_i,
   input  logic [7:0]  periph_rdata_i,
   output logic        overrun_o,
   output logic        timeout_o
);

   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

   state_t                   state_q,       state_d;
   region_t                  region_q,      region_d;
   logic [15:0]              periph_addr_q, periph_addr_d;
   logic                     write_q,       write_d;
   logic [7:0]               wdata_q,       wdata_d;
   logic [RAM_ADDR_BITS-1:0] ram_addr_q,    ram_addr_d;
   logic [7:0]               wait_cnt_q,    wait_cnt_d;
   logic [7:0]               rdata_q,       rdata_d;
   logic [7:0]               open_bus_q,    open_bus_d;
   logic [7:0]               cpu_data_q,    cpu_data_d;
   logic                     from_ram_q,    from_ram_d;
   logic                     overrun_q,     overrun_d;
   logic                     timeout_q,     timeout_d;
   logic                     ram_we;
   logic [7:0]               ram_rdata;

   // A write still in RAM_ACCESS when reset hits is dropped rather than committed.
   work_ram #(.ADDR_BITS(RAM_ADDR_BITS)) u_work_ram (
      .clock_i (clock_i),
      .addr_i  (ram_addr_q),
      .we_i    (ram_we && !reset_i),
      .wdata_i (wdata_q),
      .rdata_o (ram_rdata)
   );

   // Next-state and output decode for the bus-cycle FSM.
   always_comb begin
      // NOTE: every signal gets a default first so no path through the case infers a latch.
      state_d          = state_q;
      region_d         = region_q;
      periph_addr_d    = periph_addr_q;
      write_d          = write_q;
      wdata_d          = wdata_q;
      ram_addr_d       = ram_addr_q;
      wait_cnt_d       = wait_cnt_q;
      rdata_d          = rdata_q;
      open_bus_d       = open_bus_q;
      cpu_data_d       = cpu_data_q;
      from_ram_d       = from_ram_q;
      overrun_d        = overrun_q;
      timeout_d        = timeout_q;
      ram_we           = 1'b0;
      periph_req_o     = 1'b0;
      cpu_data_valid_o = 1'b0;

      if (cpu_address_valid_i && state_q != IDLE) overrun_d = 1'b1;

      case (state_q)
         IDLE: begin
            if (cpu_address_valid_i) begin
               ram_addr_d    = cpu_address_i[RAM_ADDR_BITS-1:0];
               region_d      = decode_region(cpu_address_i);
               periph_addr_d = periph_address(cpu_address_i);
               write_d       = cpu_data_valid_i;
               wdata_d       = cpu_data_i;
               wait_cnt_d    = 8'd0;
               // A CPU write drives the data bus, so it becomes the open-bus value.
               if (cpu_data_valid_i) open_bus_d = cpu_data_i;
               if (decode_region(cpu_address_i) == REGION_NONE) begin
                  state_d    = RAM_ACCESS;
                  from_ram_d = 1'b1;
               end else begin
                  state_d    = PERIPH_WAIT;
                  from_ram_d = 1'b0;
               end
            end
         end
         RAM_ACCESS: begin
            ram_we  = write_q;
            state_d = write_q ? IDLE : RESPOND;
         end
         PERIPH_WAIT: begin
            periph_req_o = 1'b1;
            if (periph_ack_i) begin
               rdata_d = periph_rdata_i;
               state_d = write_q ? IDLE : RESPOND;
            end else if (wait_cnt_q == TIMEOUT_LAST) begin
               timeout_d = 1'b1;
               rdata_d   = open_bus_q;
               state_d   = write_q ? IDLE : RESPOND;
            end else begin
               wait_cnt_d = wait_cnt_q + 8'd1;
            end
         end
         RESPOND: begin
            cpu_data_valid_o = 1'b1;
            cpu_data_d       = from_ram_q ? ram_rdata : rdata_q;
            open_bus_d       = cpu_data_d;
            state_d          = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers with synchronous active-high reset.
   always_ff @(posedge clock_i) begin
      // NOTE: non-blocking assignments keep every flop sampling the pre-edge values.
      if (reset_i) begin
         state_q       <= IDLE;
         region_q      <= REGION_NONE;
         periph_addr_q <= 16'h0000;
         write_q       <= 1'b0;
         wdata_q       <= 8'h00;
         ram_addr_q    <= '0;
         wait_cnt_q    <= 8'd0;
         rdata_q       <= 8'h00;
         open_bus_q    <= 8'h00;
         cpu_data_q    <= 8'h00;
         from_ram_q    <= 1'b0;
         overrun_q     <= 1'b0;
         timeout_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         region_q      <= region_d;
         periph_addr_q <= periph_addr_d;
         write_q       <= write_d;
         wdata_q       <= wdata_d;
         ram_addr_q    <= ram_addr_d;
         wait_cnt_q    <= wait_cnt_d;
         rdata_q       <= rdata_d;
         open_bus_q    <= open_bus_d;
         cpu_data_q    <= cpu_data_d;
         from_ram_q    <= from_ram_d;
         overrun_q     <= overrun_d;
         timeout_q     <= timeout_d;
      end
   end

   assign cpu_data_o       = cpu_data_d;
   assign periph_select_o  = region_q;
   assign periph_address_o = periph_addr_q;
   assign periph_write_o   = write_q;
   assign periph_wdata_o   = wdata_q;
   assign overrun_o        = overrun_q;
   assign timeout_o        = timeout_q;

endmodule

// File: tb/tb_cpu_bus_decoder.sv
// Self-checking bench for cpu_bus_decoder: directed scenarios plus randomized
// accesses compared against a transaction-level model of the NES bus map.
module tb_cpu_bus_decoder;

   localparam int T = 8;

   logic        clock_i = 1'b0;
   logic        reset_i = 1'b1;
   logic [15:0] cpu_address_i = 16'h0000;
   logic        cpu_address_valid_i = 1'b0;
   logic [7:0]  cpu_data_i = 8'h00;
   logic        cpu_data_valid_i = 1'b0;
   logic [7:0]  cpu_data_o;
   logic        cpu_data_valid_o;
   logic [1:0]  periph_select_o;
   logic [15:0] periph_address_o;
   logic        periph_write_o;
   logic [7:0]  periph_wdata_o;
   logic        periph_req_o;
   logic        periph_ack_i = 1'b0;
   logic [7:0]  periph_rdata_i = 8'h00;
   logic        overrun_o;
   logic        timeout_o;

   always #5 clock_i = ~clock_i;

   cpu_bus_decoder #(.TIMEOUT_CYCLES(T), .RAM_ADDR_BITS(11)) dut (
      .clock_i             (clock_i),
      .reset_i             (reset_i),
      .cpu_address_i       (cpu_address_i),
      .cpu_address_valid_i (cpu_address_valid_i),
      .cpu_data_i          (cpu_data_i),
      .cpu_data_valid_i    (cpu_data_valid_i),
      .cpu_data_o          (cpu_data_o),
      .cpu_data_valid_o    (cpu_data_valid_o),
      .periph_select_o     (periph_select_o),
      .periph_address_o    (periph_address_o),
      .periph_write_o      (periph_write_o),
      .periph_wdata_o      (periph_wdata_o),
      .periph_req_o        (periph_req_o),
      .periph_ack_i        (periph_ack_i),
      .periph_rdata_i      (periph_rdata_i),
      .overrun_o           (overrun_o),
      .timeout_o           (timeout_o)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state: RAM image, open-bus byte and sticky flags.
   logic [7:0]  m_mem [2048];
   bit          m_known [2048];
   logic [10:0] m_written [$];
   logic [7:0]  m_open_bus = 8'h00;
   bit          m_timeout = 0;
   bit          m_overrun = 0;

   // Observations from the most recent access.
   int          o_req_cycles;
   int          o_vcount;
   int          o_vcyc;
   logic [7:0]  o_vdata;

   task automatic tick();
      @(posedge clock_i);
      #1;
   endtask

   // One CPU bus cycle: strobe, watch a fixed window, compare with the model.
   task automatic do_access(input logic [15:0] addr, input bit wr, input logic [7:0] wd,
                            input int ack_after, input logic [7:0] rd,
                            input int inject_cyc, input string tag);
      bit          is_ram   = addr < 16'h2000;
      int          idx      = int'(addr) % 2048;
      bit          acked    = !is_ram && ack_after >= 1 && ack_after <= T;
      int          exp_req  = is_ram ? 0 : (acked ? ack_after : T);
      int          exp_vcyc = is_ram ? 2 : exp_req + 1;
      logic [1:0]  exp_sel;
      logic [15:0] exp_addr;
      logic [7:0]  exp_data;
      logic [26:0] first_v = '0;
      bit          stable = 1;
      int          expected_vcount = wr ? 0 : 1;

      if (is_ram)                exp_sel = 2'd0;
      else if (addr < 16'h4000)  exp_sel = 2'd1;
      else if (addr < 16'h4020)  exp_sel = 2'd2;
      else                       exp_sel = 2'd3;
      exp_addr = (exp_sel == 2'd1) ? 16'(16'h2000 + int'(addr) % 8) : addr;
      if (is_ram) exp_data = m_mem[idx];
      else        exp_data = acked ? rd : m_open_bus;

      o_req_cycles = 0; o_vcount = 0; o_vcyc = 0; o_vdata = 8'h00;
      cpu_address_i = addr; cpu_address_valid_i = 1'b1;
      cpu_data_valid_i = wr; cpu_data_i = wd;
      tick();
      cpu_address_valid_i = 1'b0; cpu_data_valid_i = 1'b0;
      cpu_address_i = 16'($urandom); cpu_data_i = 8'($urandom);
      for (int cyc = 1; cyc <= T + 6; cyc++) begin
         periph_ack_i = 1'b0;
         periph_rdata_i = 8'($urandom);
         if (cyc == inject_cyc) begin
            cpu_address_i = 16'h0123; cpu_address_valid_i = 1'b1;
            cpu_data_valid_i = 1'b1; cpu_data_i = 8'hEE;
         end
         if (periph_req_o) begin
            o_req_cycles++;
            if (o_req_cycles == 1)
               first_v = {periph_select_o, periph_address_o, periph_write_o, periph_wdata_o};
            else if (first_v !== {periph_select_o, periph_address_o, periph_write_o, periph_wdata_o})
               stable = 0;
            if (o_req_cycles == ack_after) begin
               periph_ack_i = 1'b1; periph_rdata_i = rd;
            end
         end else if ($urandom_range(0, 3) == 0) begin
            periph_ack_i = 1'b1;  // stray ack outside a request must be ignored
         end
         if (cpu_data_valid_o) begin
            o_vcount++; o_vcyc = cyc; o_vdata = cpu_data_o;
         end
         tick();
         cpu_address_valid_i = 1'b0; cpu_data_valid_i = 1'b0;
      end
      periph_ack_i = 1'b0;

      if (!is_ram && !acked) m_timeout = 1;
      if (inject_cyc > 0)    m_overrun = 1;

      n_cmp++;
      if (o_req_cycles !== exp_req) begin
         n_bad++; $display("FAIL %s req_cycles: got %0d want %0d", tag, o_req_cycles, exp_req);
      end
      if (!is_ram) begin
         n_cmp++;
         if (first_v[26:25] !== exp_sel || first_v[24:9] !== exp_addr || first_v[8] !== wr) begin
            n_bad++;
            $display("FAIL %s periph sel/addr/write: got %0d/%h/%0d want %0d/%h/%0d",
                     tag, first_v[26:25], first_v[24:9], first_v[8], exp_sel, exp_addr, wr);
         end
         if (wr) begin
            n_cmp++;
            if (first_v[7:0] !== wd) begin
               n_bad++; $display("FAIL %s periph_wdata: got %h want %h", tag, first_v[7:0], wd);
            end
         end
         n_cmp++;
         if (!stable) begin
            n_bad++; $display("FAIL %s periph outputs unstable during request: got 0 want 1", tag);
         end
      end
      n_cmp++;
      if (o_vcount !== expected_vcount) begin
         n_bad++; $display("FAIL %s valid pulses: got %0d want %0d", tag, o_vcount, expected_vcount);
      end
      if (!wr) begin
         n_cmp++;
         if (o_vcyc !== exp_vcyc || o_vdata !== exp_data) begin
            n_bad++;
            $display("FAIL %s read cycle/data: got %0d/%h want %0d/%h", tag, o_vcyc, o_vdata, exp_vcyc, exp_data);
         end
      end
      n_cmp++;
      if (timeout_o !== m_timeout || overrun_o !== m_overrun) begin
         n_bad++;
         $display("FAIL %s flags timeout/overrun: got %0d/%0d want %0d/%0d",
                  tag, timeout_o, overrun_o, m_timeout, m_overrun);
      end

      if (wr) begin
         if (is_ram) begin
            m_mem[idx] = wd;
            if (!m_known[idx]) m_written.push_back(11'(idx));
            m_known[idx] = 1;
         end
         m_open_bus = wd;
      end else begin
         m_open_bus = exp_data;
      end
   endtask

   task automatic test_reset();
      reset_i = 1'b1;
      tick(); tick();
      reset_i = 1'b0;
      n_cmp++;
      if ({cpu_data_o, cpu_data_valid_o, periph_select_o, periph_address_o, periph_write_o,
           periph_wdata_o, periph_req_o, overrun_o, timeout_o} !== 40'd0) begin
         n_bad++;
         $display("FAIL reset outputs: got data=%h v=%0d sel=%0d addr=%h w=%0d wd=%h req=%0d ov=%0d to=%0d want all zero",
                  cpu_data_o, cpu_data_valid_o, periph_select_o, periph_address_o, periph_write_o,
                  periph_wdata_o, periph_req_o, overrun_o, timeout_o);
      end
   endtask

   task automatic test_ram_mirror();
      do_access(16'h0005, 1, 8'hA5, 0, 8'h00, 0, "ram_write");
      do_access(16'h1805, 0, 8'h00, 0, 8'h00, 0, "ram_mirror_read");
      n_cmp++;
      if (o_vdata !== 8'hA5 || o_vcyc !== 2) begin
         n_bad++; $display("FAIL ram_mirror: got %h@%0d want a5@2", o_vdata, o_vcyc);
      end
   endtask

   task automatic test_ppu_read();
      do_access(16'h2009, 0, 8'h00, 3, 8'h3C, 0, "ppu_read");
      n_cmp++;
      if (o_vdata !== 8'h3C || o_vcount !== 1) begin
         n_bad++; $display("FAIL ppu_read data/pulses: got %h/%0d want 3c/1", o_vdata, o_vcount);
      end
   endtask

   task automatic test_ack_at_timeout();
      do_access(16'h6000, 0, 8'h00, T, 8'hC7, 0, "ack_at_timeout");
      n_cmp++;
      if (o_vdata !== 8'hC7 || timeout_o !== 1'b0) begin
         n_bad++; $display("FAIL ack_at_timeout data/timeout: got %h/%0d want c7/0", o_vdata, timeout_o);
      end
   endtask

   task automatic test_timeout();
      do_access(16'h8000, 1, 8'h12, 0, 8'h00, 0, "timeout_write");
      n_cmp++;
      if (o_req_cycles !== T || timeout_o !== 1'b1 || o_vcount !== 0) begin
         n_bad++; $display("FAIL timeout_write req/timeout/pulses: got %0d/%0d/%0d want 8/1/0",
                           o_req_cycles, timeout_o, o_vcount);
      end
      do_access(16'hC000, 0, 8'h00, 0, 8'h00, 0, "timeout_read");
      n_cmp++;
      if (o_vdata !== 8'h12 || timeout_o !== 1'b1) begin
         n_bad++; $display("FAIL open_bus_read data/timeout: got %h/%0d want 12/1", o_vdata, timeout_o);
      end
   endtask

   task automatic test_overrun();
      do_access(16'h0123, 1, 8'h5A, 0, 8'h00, 0, "overrun_pre");
      do_access(16'h4016, 0, 8'h00, 4, 8'h81, 2, "overrun");
      n_cmp++;
      if (overrun_o !== 1'b1 || o_vdata !== 8'h81) begin
         n_bad++; $display("FAIL overrun flag/data: got %0d/%h want 1/81", overrun_o, o_vdata);
      end
      do_access(16'h0923, 0, 8'h00, 0, 8'h00, 0, "overrun_ram_untouched");
      n_cmp++;
      if (o_vdata !== 8'h5A) begin
         n_bad++; $display("FAIL overrun_ignored_write: got %h want 5a", o_vdata);
      end
   endtask

   task automatic test_reset_mid_periph();
      int seen = 0;
      cpu_address_i = 16'h4015; cpu_address_valid_i = 1'b1; cpu_data_valid_i = 1'b0;
      tick();
      cpu_address_valid_i = 1'b0;
      tick(); tick();
      n_cmp++;
      if (periph_req_o !== 1'b1) begin
         n_bad++; $display("FAIL reset_mid req_before: got %0d want 1", periph_req_o);
      end
      reset_i = 1'b1;
      tick();
      reset_i = 1'b0;
      m_timeout = 0; m_overrun = 0; m_open_bus = 8'h00;
      n_cmp++;
      if ({periph_req_o, timeout_o, overrun_o, cpu_data_valid_o, cpu_data_o} !== 12'd0) begin
         n_bad++;
         $display("FAIL reset_mid state: got req=%0d to=%0d ov=%0d v=%0d data=%h want all zero",
                  periph_req_o, timeout_o, overrun_o, cpu_data_valid_o, cpu_data_o);
      end
      for (int i = 0; i < 12; i++) begin
         periph_ack_i = 1'($urandom_range(0, 1));
         if (periph_req_o || cpu_data_valid_o) seen++;
         tick();
      end
      periph_ack_i = 1'b0;
      n_cmp++;
      if (seen !== 0) begin
         n_bad++; $display("FAIL reset_mid activity after reset: got %0d want 0", seen);
      end
   endtask

   task automatic test_reset_ram_write();
      do_access(16'h0042, 1, 8'h11, 0, 8'h00, 0, "ram_pre");
      cpu_address_i = 16'h0042; cpu_address_valid_i = 1'b1;
      cpu_data_valid_i = 1'b1; cpu_data_i = 8'h99;
      tick();
      cpu_address_valid_i = 1'b0; cpu_data_valid_i = 1'b0;
      reset_i = 1'b1;
      tick();
      reset_i = 1'b0;
      m_timeout = 0; m_overrun = 0; m_open_bus = 8'h00;
      do_access(16'h1842, 0, 8'h00, 0, 8'h00, 0, "ram_write_discarded");
      n_cmp++;
      if (o_vdata !== 8'h11) begin
         n_bad++; $display("FAIL reset_discards_write: got %h want 11", o_vdata);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 40; n++) begin
         int          r  = int'($urandom_range(0, 3));
         bit          wr = 1'($urandom_range(0, 1));
         int          ack = int'($urandom_range(0, T + 2));
         logic [15:0] addr;
         case (r)
            0:       addr = 16'($urandom_range(0, 16'h1FFF));
            1:       addr = 16'(16'h2000 + $urandom_range(0, 16'h1FFF));
            2:       addr = 16'(16'h4000 + $urandom_range(0, 31));
            default: addr = 16'(16'h4020 + $urandom_range(0, 16'hFFFF - 16'h4020));
         endcase
         if (r == 0 && !wr) begin
            if (m_written.size() == 0) wr = 1;
            else addr = 16'(int'(m_written[$urandom_range(0, m_written.size() - 1)])
                            + 2048 * int'($urandom_range(0, 3)));
         end
         do_access(addr, wr, 8'($urandom), ack, 8'($urandom), 0, $sformatf("random%0d", n));
      end
   endtask

   initial begin
      test_reset();
      test_ram_mirror();
      test_ppu_read();
      test_ack_at_timeout();
      test_timeout();
      test_overrun();
      test_reset_mid_periph();
      test_reset_ram_write();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
